// File: rtl/spi_sram_responder.sv
// SPI mode-0 slave fronting a small byte-addressed SRAM (READ 0x03, WRITE 0x02, 24-bit address).
// Define SPI_SRAM_FAST_READ_EN to also accept FAST READ 0x0B with 8 dummy clocks.
module spi_sram_responder #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs_n,
  input  logic       mosi,
  output logic       miso,
  output logic       miso_oe,
  output logic       busy,
  output logic [7:0] last_cmd
);

`ifdef SPI_SRAM_FAST_READ_EN
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, RD, WR, IGNORE} state_t;
`else
  typedef enum logic [2:0] {IDLE, CMD, ADDR, RD, WR, IGNORE} state_t;
`endif

  logic [7:0]    mem [DEPTH];

  logic [2:0]    sck_s_q;
  logic [1:0]    cs_s_q;
  logic [1:0]    mosi_s_q;

  state_t        state_q, state_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [6:0]    sh_q, sh_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    tx_q, tx_d;
  logic          miso_q, miso_d;
  logic [7:0]    last_cmd_q, last_cmd_d;
  logic          mem_we;
  logic [7:0]    mem_wdata;

  logic sck_rise, sck_fall, cs_hi, mosi_s;
  assign sck_rise = sck_s_q[1] & ~sck_s_q[2];
  assign sck_fall = ~sck_s_q[1] & sck_s_q[2];
  assign cs_hi    = cs_s_q[1];
  assign mosi_s   = mosi_s_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_s_q    <= '0;
      cs_s_q     <= 2'b11;
      mosi_s_q   <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      addr_q     <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      last_cmd_q <= 8'h00;
    end else begin
      sck_s_q    <= {sck_s_q[1:0], sck};
      cs_s_q     <= {cs_s_q[0], cs_n};
      mosi_s_q   <= {mosi_s_q[0], mosi};
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      addr_q     <= addr_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      last_cmd_q <= last_cmd_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= mem_wdata;
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sh_d       = sh_q;
    addr_d     = addr_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    last_cmd_d = last_cmd_q;
    mem_we     = 1'b0;
    mem_wdata  = {sh_q, mosi_s};
    // A deasserted select overrides any SCK edge seen in the same cycle.
    if (cs_hi) begin
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = CMD;
          bit_cnt_d = '0;
          sh_d      = '0;
        end
        CMD: if (sck_rise) begin
          sh_d      = {sh_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            last_cmd_d = {sh_q, mosi_s};
            bit_cnt_d  = '0;
            case ({sh_q, mosi_s})
              8'h03, 8'h02: state_d = ADDR;
`ifdef SPI_SRAM_FAST_READ_EN
              8'h0B:        state_d = ADDR;
`endif
              default:      state_d = IGNORE;
            endcase
          end
        end
        ADDR: if (sck_rise) begin
          addr_d    = {addr_q[AW-2:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd23) begin
            bit_cnt_d = '0;
            if (last_cmd_q == 8'h03) begin
              tx_d    = mem[addr_d];
              state_d = RD;
            end else if (last_cmd_q == 8'h02) begin
              state_d = WR;
            end else begin
`ifdef SPI_SRAM_FAST_READ_EN
              state_d = DUMMY;
`else
              state_d = IGNORE;
`endif
            end
          end
        end
`ifdef SPI_SRAM_FAST_READ_EN
        DUMMY: if (sck_rise) begin
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            tx_d      = mem[addr_q];
            state_d   = RD;
          end
        end
`endif
        RD: if (sck_fall) begin
          miso_d    = tx_q[7];
          tx_d      = {tx_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          // Prefetch the next byte right after bit 0 leaves.
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            addr_d    = addr_q + AW'(1);
            tx_d      = mem[addr_q + AW'(1)];
          end
        end
        WR: if (sck_rise) begin
          sh_d      = {sh_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd7) begin
            bit_cnt_d = '0;
            mem_we    = 1'b1;
            addr_d    = addr_q + AW'(1);
          end
        end
        IGNORE: miso_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  assign miso     = miso_q;
  assign miso_oe  = (state_q == RD);
  assign busy     = ~cs_hi;
  assign last_cmd = last_cmd_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: SPI mode-0 master tasks and hand-computed expectations.
module tb_spi_sram_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic       miso;
  logic       miso_oe;
  logic       busy;
  logic [7:0] last_cmd;

  int checks = 0;
  int failures = 0;
  logic oe_seen;
  logic miso_seen;
  logic [7:0] rx;

  spi_sram_responder #(.DEPTH(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .busy(busy), .last_cmd(last_cmd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    oe_seen = 1'b0;
    miso_seen = 1'b0;
    wait_clk(10);
  endtask

  task automatic cs_high();
    wait_clk(6);
    cs_n = 1'b1;
    wait_clk(10);
  endtask

  // Each bit: 5 clk low with mosi set, rise (master samples miso), 5 clk high, fall.
  task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rxb);
    rxb = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      wait_clk(5);
      sck = 1'b1;
      rxb = {rxb[6:0], miso};
      oe_seen = oe_seen | miso_oe;
      miso_seen = miso_seen | miso;
      wait_clk(5);
      sck = 1'b0;
    end
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rxb);
    xfer_bits(tx, 8, rxb);
  endtask

  task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
    logic [7:0] d;
    xfer_byte(cmd, d);
    xfer_byte(addr[23:16], d);
    xfer_byte(addr[15:8], d);
    xfer_byte(addr[7:0], d);
  endtask

  task automatic write2(input logic [23:0] addr, input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] d;
    cs_low();
    send_hdr(8'h02, addr);
    xfer_byte(b0, d);
    xfer_byte(b1, d);
    cs_high();
  endtask

  initial begin
    // Reset with select idle
    wait_clk(3);
    check("rst_miso", {31'd0, miso}, 32'd0);
    check("rst_oe", {31'd0, miso_oe}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_last_cmd", {24'd0, last_cmd}, 32'h00);
    rst = 1'b0;
    wait_clk(20);
    check("idle_miso", {31'd0, miso}, 32'd0);
    check("idle_oe", {31'd0, miso_oe}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_last_cmd", {24'd0, last_cmd}, 32'h00);

    // Write then read back
    write2(24'h000010, 8'hA5, 8'h3C);
    check("wr_last_cmd", {24'd0, last_cmd}, 32'h02);
    cs_low();
    check("busy_low", {31'd0, busy}, 32'd1);
    send_hdr(8'h03, 24'h000010);
    check("rd_oe_active", {31'd0, miso_oe}, 32'd1);
    xfer_byte(8'h00, rx);
    check("rd_b0", {24'd0, rx}, 32'hA5);
    xfer_byte(8'h00, rx);
    check("rd_b1", {24'd0, rx}, 32'h3C);
    check("rd_last_cmd", {24'd0, last_cmd}, 32'h03);
    cs_high();
    check("end_oe", {31'd0, miso_oe}, 32'd0);
    check("end_miso", {31'd0, miso}, 32'd0);
    check("end_busy", {31'd0, busy}, 32'd0);

    // Address wrap
    write2(24'h0000FF, 8'h11, 8'h22);
    cs_low();
    send_hdr(8'h03, 24'h0000FF);
    xfer_byte(8'h00, rx);
    check("wrap_b0", {24'd0, rx}, 32'h11);
    xfer_byte(8'h00, rx);
    check("wrap_b1", {24'd0, rx}, 32'h22);
    cs_high();
    cs_low();
    send_hdr(8'h03, 24'h000000);
    xfer_byte(8'h00, rx);
    check("wrap_at0", {24'd0, rx}, 32'h22);
    cs_high();

    // Aborted write keeps the old byte
    write2(24'h000020, 8'h5A, 8'h77);
    cs_low();
    send_hdr(8'h02, 24'h000020);
    xfer_bits(8'hFF, 5, rx);
    cs_high();
    cs_low();
    send_hdr(8'h03, 24'h000020);
    xfer_byte(8'h00, rx);
    check("abort_keep", {24'd0, rx}, 32'h5A);
    xfer_byte(8'h00, rx);
    check("abort_next", {24'd0, rx}, 32'h77);
    cs_high();

    // Unknown command shaped like a write
    cs_low();
    send_hdr(8'h9F, 24'h000010);
    xfer_byte(8'hFF, rx);
    check("unk_oe", {31'd0, oe_seen}, 32'd0);
    check("unk_miso", {31'd0, miso_seen}, 32'd0);
    check("unk_last_cmd", {24'd0, last_cmd}, 32'h9F);
    cs_high();
    cs_low();
    send_hdr(8'h03, 24'h000010);
    xfer_byte(8'h00, rx);
    check("unk_mem", {24'd0, rx}, 32'hA5);
    cs_high();

    // Fast read
    cs_low();
    send_hdr(8'h0B, 24'h000010);
    xfer_byte(8'hFF, rx);
    oe_seen = 1'b0;
    xfer_byte(8'h00, rx);
`ifdef SPI_SRAM_FAST_READ_EN
    check("fast_data", {24'd0, rx}, 32'hA5);
    check("fast_oe", {31'd0, oe_seen}, 32'd1);
`else
    check("fast_data", {24'd0, rx}, 32'h00);
    check("fast_oe", {31'd0, oe_seen}, 32'd0);
`endif
    check("fast_last_cmd", {24'd0, last_cmd}, 32'h0B);
    cs_high();

    // Reset mid-read, then a fresh transaction
    cs_low();
    send_hdr(8'h03, 24'h000010);
    xfer_bits(8'h00, 3, rx);
    rst = 1'b1;
    wait_clk(2);
    check("midrst_oe", {31'd0, miso_oe}, 32'd0);
    check("midrst_last_cmd", {24'd0, last_cmd}, 32'h00);
    cs_n = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(5);
    cs_low();
    send_hdr(8'h03, 24'h000011);
    xfer_byte(8'h00, rx);
    check("post_rst_rd", {24'd0, rx}, 32'h3C);
    cs_high();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_sram_responder.md
Name: spi_sram_responder

Overview:
- SPI-slave byte-addressed SRAM: the responder end of the SPI RAM bus driven by the SoC's mapped SPI RAM master.
- Used as an on-chip stand-in for the external SPI SRAM (bring-up and self-test) and as a bench target.
- Serves READ 0x03 and WRITE 0x02 with a 24-bit address and streaming data; address auto-increments.
- Oversamples SCK/CS_N/MOSI with the system clock; the SPI side is fully synchronous to clk.

Parameters:
- DEPTH, 256, bytes of internal storage (power of 2); address used modulo DEPTH
- AW, 8, log2(DEPTH)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- sck  in  1  SPI clock, mode 0, idle low
- cs_n  in  1  SPI chip select, active-low
- mosi  in  1  SPI data in, MSB first
- miso  out  1  SPI data out, MSB first
- miso_oe  out  1  high while a READ data phase is active
- busy  out  1  high while cs_n is synchronised low
- last_cmd  out  8  last command byte received (debug)

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: miso=0, miso_oe=0, busy=0, last_cmd=8'h00, state=IDLE, counters=0. Memory contents are not reset.
- Sync: sck, cs_n and mosi each pass through 2-flop synchronisers. Rise/fall is detected from the 2nd and 3rd sck stages. Action occurs 3 clk after the pin edge.
- Requirement: each SCK high and low phase ≥ 4 clk periods (f_clk ≥ 8·f_sck).
- Mode 0: mosi sampled on detected SCK rise; miso updated on detected SCK fall.
- States:
  - IDLE: cs_n high. A cs_n fall → CMD, with bit count and shift register cleared.
  - CMD: 8 rises shift the command byte; last_cmd is updated on the 8th rise. 0x03 or 0x02 → ADDR; any other value → IGNORE.
  - ADDR: 24 rises shift the address; only addr[AW-1:0] is kept.
    - On the 24th rise a READ loads tx_shift with mem[addr] and goes to RD.
    - On the 24th rise a WRITE goes to WR.
  - RD: miso_oe=1. Each fall: miso ← tx_shift[7], tx_shift ← tx_shift<<1, bit count +1. After the fall that outputs bit 0, addr ← addr+1 and tx_shift ← mem[addr+1], ready for the next fall.
  - WR: rises shift mosi into rx_byte. On the 8th rise, mem[addr] ← byte and addr ← addr+1 in the same clk.
  - IGNORE: miso=0, miso_oe=0; wait for cs_n high.
- Address wraps from DEPTH-1 to 0 in both RD and WR.
- cs_n rise (synchronised) in any state → IDLE on the next clk; miso_oe=0, miso=0.
  - A partial write byte (<8 bits) is discarded; memory is unchanged.
  - A partial read has no side effects.
- cs_n rise and an SCK edge detected in the same clk: cs_n wins and the edge is ignored.
- rst asserted mid-transaction: immediate return to reset values; the next transaction needs a fresh cs_n fall.
- busy follows the synchronised cs_n inverted; it is not affected by state.

Optional Feature:
- Macro: SPI_SRAM_FAST_READ_EN.
- Defined: command 0x0B (FAST READ) is accepted. ADDR is followed by a DUMMY state of 8 rises (mosi ignored). mem[addr] is loaded on the 8th dummy rise, then RD behaves as for 0x03.
- Undefined: 0x0B is treated as an unknown command → IGNORE. The DUMMY state logic is absent.

Test Plan:
- Reset: assert rst with cs_n=1 → miso=0, miso_oe=0, busy=0, last_cmd=0x00; deassert, idle 20 clk → outputs unchanged.
- Write/read-back: WRITE 0x02, addr 0x000010, data 0xA5,0x3C → READ 0x03 addr 0x000010 for 2 bytes returns 0xA5,0x3C; last_cmd=0x03.
- Wrap: WRITE addr 0x0000FF, data 0x11,0x22 (DEPTH=256) → read from 0x0000FF returns 0x11,0x22; read from 0x000000 returns 0x22.
- Aborted write: WRITE addr 0x20, then only 5 data bits, then cs_n high → read 0x20 returns the prior value; the state machine accepts the next transaction normally.
- Unknown command: 0x9F followed by 32 SCK cycles → miso_oe stays 0, miso stays 0, last_cmd=0x9F, memory unchanged.
- Fast read (macro defined): 0x0B, addr 0x10, dummy 0xFF → 0xA5 is read back. With the macro undefined, the same stimulus → miso_oe stays 0.
